// File: rtl/qpsk_byte_framer_if.sv
// Symbol-in / byte-out bundle for qpsk_byte_framer.
// The framer attaches through the slave modport; the upstream/downstream side uses master.
interface qpsk_byte_framer_if;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;

    modport slave (
        input  sym_in,
        input  sym_valid,
        input  byte_ready,
        output byte_out,
        output byte_valid
    );

    modport master (
        output sym_in,
        output sym_valid,
        output byte_ready,
        input  byte_out,
        input  byte_valid
    );
endinterface

// File: rtl/qpsk_byte_framer.sv
// QPSK dibit framer: sync hunt, MSB-first byte assembly and an FWFT output FIFO.
// Define QPSK_FRAMER_SYNC_INV_EN to also lock on the inverted sync word (180 degree ambiguity).
module qpsk_byte_framer #(
    parameter logic [15:0] SYNC_WORD   = 16'hF628,
    parameter int          FRAME_BYTES = 8,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                CLOCK_256,
    input  logic                reset,
    qpsk_byte_framer_if.slave   bus,
    output logic                locked,
    output logic                frame_done,
    output logic                overflow,
    output logic                phase_inv
);
`ifdef QPSK_FRAMER_SYNC_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam int         AW         = $clog2(FIFO_DEPTH);
    localparam logic [7:0] FRAME_LAST = 8'(FRAME_BYTES - 1);
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t      state_q;
    logic [15:0] hunt_q;
    logic [5:0]  byte_sr_q;
    logic [1:0]  sym_cnt_q;
    logic [7:0]  byte_cnt_q;
    logic        locked_q;
    logic        frame_done_q;
    logic        phase_inv_q;
    logic        overflow_q;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;

    logic [15:0] hunt_d;
    logic [1:0]  sym_eff;
    logic [7:0]  push_byte;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic        wr_en;

    always_comb begin
        hunt_d    = {hunt_q[13:0], bus.sym_in};
        sym_eff   = (INV_EN && phase_inv_q) ? ~bus.sym_in : bus.sym_in;
        push_byte = {byte_sr_q, sym_eff};
        push      = (state_q == LOCKED) && bus.sym_valid && (sym_cnt_q == 2'd3);
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && bus.byte_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign wr_en      = push && (!fifo_full || pop);

    always_ff @(posedge CLOCK_256) begin
        if (!reset) begin
            state_q      <= HUNT;
            hunt_q       <= '0;
            byte_sr_q    <= '0;
            sym_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            phase_inv_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (bus.sym_valid) begin
                case (state_q)
                    HUNT: begin
                        hunt_q <= hunt_d;
                        if (hunt_d == SYNC_WORD) begin
                            state_q     <= LOCKED;
                            locked_q    <= 1'b1;
                            phase_inv_q <= 1'b0;
                        end else if (INV_EN && (hunt_d == ~SYNC_WORD)) begin
                            state_q     <= LOCKED;
                            locked_q    <= 1'b1;
                            phase_inv_q <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        byte_sr_q <= {byte_sr_q[3:0], sym_eff};
                        sym_cnt_q <= sym_cnt_q + 2'd1;
                        if (sym_cnt_q == 2'd3) begin
                            if (byte_cnt_q == FRAME_LAST) begin
                                state_q      <= HUNT;
                                locked_q     <= 1'b0;
                                frame_done_q <= 1'b1;
                                phase_inv_q  <= 1'b0;
                                hunt_q       <= '0;
                                byte_cnt_q   <= '0;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 8'd1;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_256) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge CLOCK_256) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_byte;
        end
    end

    assign bus.byte_out   = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.byte_valid = !fifo_empty;
    assign locked         = locked_q;
    assign frame_done     = frame_done_q;
    assign overflow       = overflow_q;
    assign phase_inv      = INV_EN & phase_inv_q;
endmodule

// File: doc/qpsk_byte_framer.md
Name: qpsk_byte_framer

Overview:
- Sits directly downstream of the QPSK demodulator.
- Consumes the 2-bit symbol stream taken from demod_bits[1:0].
- Hunts for a sync word, then assembles the following symbols into bytes, MSB first, for a fixed-length frame.
- Buffers the bytes in a small first-word-fall-through (FWFT) FIFO with a valid/ready output handshake toward the link-layer consumer.

Parameters:
- SYNC_WORD, 16'hF628, sync pattern; its first symbol received is bits [15:14].
- FRAME_BYTES, 8, payload bytes per frame after sync; legal range 1..255.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2.

Ports:
- CLOCK_256  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- sym_in  in  2  demodulated symbol (dibit), sampled when sym_valid=1.
- sym_valid  in  1  symbol strobe, one symbol per cycle at most.
- byte_out  out  8  FIFO head byte.
- byte_valid  out  1  FIFO not empty.
- byte_ready  in  1  consumer accepts byte_out this cycle.
- locked  out  1  high while in the LOCKED state.
- frame_done  out  1  one-cycle pulse at frame end.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- phase_inv  out  1  inverted sync was detected (always 0 unless SYNC_INV_EN).

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=HUNT; hunt register=0; symbol count=0; byte count=0.
  - FIFO emptied; partial byte discarded.
  - byte_out=8'h00, byte_valid=0, locked=0, frame_done=0, overflow=0, phase_inv=0.
  - Reset mid-frame discards everything; a new sync is required.
- sym_valid=0: no change to hunt/assembly state. The FIFO still pops on handshake.
- HUNT:
  - On each sym_valid, hunt_sr <= {hunt_sr[13:0], sym_in}.
  - If the updated value == SYNC_WORD, go to LOCKED. locked rises the cycle after the last sync symbol is accepted.
  - Symbols received in HUNT never reach the FIFO.
- LOCKED:
  - Symbols shift into the byte register: 1st symbol -> bits[7:6], 4th -> bits[1:0].
  - Symbol counter runs 0..3 and wraps to 0.
  - On the edge that accepts the 4th symbol, the byte is pushed to the FIFO and the byte counter increments. With the FIFO empty, byte_valid=1 and byte_out=byte on the next cycle (latency 1 cycle after the 4th symbol).
  - When the byte counter reaches FRAME_BYTES on that edge:
    - frame_done=1 for the next cycle only;
    - state goes to HUNT and locked=0 in that same cycle;
    - hunt_sr, symbol count and byte count are cleared.
  - The symbol on the very next sym_valid is the first candidate sync symbol.
- FIFO (FWFT):
  - Pop when byte_valid & byte_ready.
  - byte_out=8'h00 whenever empty.
  - Push while full and no pop: the byte is dropped, overflow <= 1 until reset, and the frame continues counting the dropped byte.
  - Push and pop while full: both happen and no drop occurs.
  - Push and pop while empty: the push lands; byte_valid=1 next cycle.
  - The FIFO keeps draining after the return to HUNT. Bytes already buffered are unaffected by new sync hunting.
- Pointers: log2(FIFO_DEPTH) bits plus a wrap bit; full/empty are derived from the pointers. Pointer wrap-around must be transparent to data order.
- No combinational path from byte_ready to byte_valid/byte_out.

Optional Feature:
- Macro: QPSK_FRAMER_SYNC_INV_EN.
- Defined:
  - HUNT also matches ~SYNC_WORD (default 16'h09D7), resolving the 180° carrier ambiguity.
  - On an inverted match, phase_inv <= 1 and every symbol in that frame is complemented (~sym_in) before byte assembly.
  - phase_inv clears on return to HUNT and on reset.
  - A non-inverted match sets phase_inv=0.
- Undefined: only SYNC_WORD matches; phase_inv is tied to 0.

Test Plan:
- Reset:
  - Hold reset=0 for 2 cycles with random sym_in/sym_valid -> all outputs 0.
  - Release -> locked stays 0.
- Nominal frame:
  - Stimulus: byte_ready=1; symbols 3,3,1,2,0,2,2,0 (0xF628), then bytes 0x00..0x07 as 32 symbols.
  - Response: locked=1 the cycle after the 8th symbol; byte_out sequence 00..07, each byte_valid 1 cycle after its 4th symbol.
  - frame_done pulses once with locked=0; then 9 more symbols produce no byte_valid.
- Near-miss sync: 3,3,1,2,0,2,2,1 then 32 symbols -> locked never 1, byte_valid never 1.
- Backpressure with gaps:
  - Stimulus: byte_ready=0; sync plus 8 bytes 0xA0..0xA7 with sym_valid=1 only every 3rd cycle.
  - Response: byte_valid=1 and FIFO holds A0..A3; overflow=1 after the 5th byte; frame_done still pulses.
  - Then byte_ready=1 -> drains exactly A0,A1,A2,A3, then byte_valid=0.
- Reset mid-frame:
  - Assert reset for 1 cycle after 2 payload bytes.
  - Response: FIFO empty, locked=0.
  - The remaining 24 symbols yield no bytes; a fresh sync plus 8 bytes works normally.
- Inverted sync (QPSK_FRAMER_SYNC_INV_EN defined):
  - Stimulus: symbols 0,0,2,1,3,1,1,3 (0x09D7), then payload symbols 1,1,2,2 (0x5A).
  - Response: phase_inv=1, byte_out=0xA5.
  - With the macro undefined, the same stimulus gives locked=0.
